// File: rtl/sll_64b_iter.sv
// Iterative 64-bit left shifter / rotator.
// Resolves BITS_PER_CYCLE shift-amount bits per clock, LSB group first.
module sll_64b_iter #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        init_i,
  input  logic        rot_i,
  input  logic [5:0]  shift_i,
  input  logic [63:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] data_o
);

  localparam int N  = 6 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [5:0] GMASK = 6'((1 << BITS_PER_CYCLE) - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [63:0]    work_q;
  logic [5:0]     amt_q;
  logic           rot_q;

  logic [5:0]     grp_mask;
  logic [5:0]     stage_amt;
  logic [63:0]    fill;
  logic [63:0]    stage_res;
  logic           last;
  int unsigned    off;

  // Keeping the group in place gives v * 2^(c*B) directly.
  always_comb begin
    off       = BITS_PER_CYCLE * int'(cnt_q);
    grp_mask  = GMASK << off;
    stage_amt = amt_q & grp_mask;
    fill      = '0;
    if (rot_q) begin
      fill = work_q >> (7'd64 - {1'b0, stage_amt});
    end
    stage_res = (work_q << stage_amt) | fill;
    last      = (cnt_q == CW'(N - 1));
  end

  assign busy_o = (state_q == SHIFT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      amt_q   <= '0;
      rot_q   <= 1'b0;
      done_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      done_o <= 1'b0;
      data_o <= '0;
      unique case (state_q)
        IDLE: begin
          if (init_i) begin
            work_q  <= data_i;
            amt_q   <= shift_i;
            rot_q   <= rot_i;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= stage_res;
          if (last) begin
            done_o  <= 1'b1;
            data_o  <= stage_res;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sll_64b_iter.sv
// Bench for sll_64b_iter: four widths side by side, each
// tracked by a cycle-level model; directed vectors pin B=2.
module tb_sll_64b_iter;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic        rot;
  logic [5:0]  shamt;
  logic [63:0] din;

  logic        busy [4];
  logic        done [4];
  logic [63:0] dout [4];

  int nvec = 0;
  int nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Bit-by-bit placement: bit i lands at i+s, wrapping only for rotate.
  function automatic logic [63:0] golden(logic [63:0] d, int s, logic r);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      if (r || (i + s) < 64) o[(i + s) % 64] = d[i];
    end
    return o;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
    localparam int N = 6 / B;

    sll_64b_iter #(.BITS_PER_CYCLE(B)) u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .init_i  (init),
      .rot_i   (rot),
      .shift_i (shamt),
      .data_i  (din),
      .busy_o  (busy[g]),
      .done_o  (done[g]),
      .data_o  (dout[g])
    );

    int          left;
    logic [63:0] res;
    logic        m_done;
    logic [63:0] m_data;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        left   <= 0;
        res    <= '0;
        m_done <= 1'b0;
        m_data <= '0;
      end else begin
        m_done <= 1'b0;
        m_data <= '0;
        if (left > 0) begin
          left <= left - 1;
          if (left == 1) begin
            m_done <= 1'b1;
            m_data <= res;
          end
        end else if (init) begin
          left <= N;
          res  <= golden(din, int'(shamt), rot);
        end
      end
    end

    always @(posedge clk) begin
      #1;
      check($sformatf("B%0d busy", B), 64'(busy[g]), 64'(left > 0));
      check($sformatf("B%0d done", B), 64'(done[g]), 64'(m_done));
      check($sformatf("B%0d data", B), dout[g], m_data);
    end
  end

  task automatic run_op(string nm, logic [63:0] d, logic [5:0] s,
                        logic r, logic [63:0] exp);
    int n;
    @(negedge clk);
    init  = 1'b1;
    din   = d;
    shamt = s;
    rot   = r;
    @(negedge clk);
    init  = 1'b0;
    din   = ~d;
    shamt = ~s;
    rot   = ~r;
    n = 1;
    while (!done[1] && n < 10) begin
      check({nm, " busy"}, 64'(busy[1]), 64'd1);
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 64'(n - 1), 64'd3);
    check({nm, " result"}, dout[1], exp);
    check({nm, " busy at done"}, 64'(busy[1]), 64'd0);
    @(negedge clk);
    check({nm, " done width"}, 64'(done[1]), 64'd0);
    check({nm, " data after"}, dout[1], 64'd0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    init  = 1'b0;
    rot   = 1'b0;
    shamt = '0;
    din   = '0;
    #1;
    check("reset busy", 64'(busy[1]), 64'd0);
    check("reset done", 64'(done[1]), 64'd0);
    check("reset data", dout[1], 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("shl63", 64'h1, 6'd63, 1'b0, 64'h8000_0000_0000_0000);
    run_op("rol1", 64'h8000_0000_0000_0001, 6'd1, 1'b1, 64'h3);
    run_op("shl1", 64'h8000_0000_0000_0001, 6'd1, 1'b0, 64'h2);
    run_op("zero", 64'hDEAD_BEEF_CAFE_F00D, 6'd0, 1'b0,
           64'hDEAD_BEEF_CAFE_F00D);
    run_op("rol36", 64'h0123_4567_89AB_CDEF, 6'd36, 1'b1,
           64'h9ABC_DEF0_1234_5678);
    run_op("shl36", 64'h0123_4567_89AB_CDEF, 6'd36, 1'b0,
           64'h9ABC_DEF0_0000_0000);
    run_op("rol63", 64'h1, 6'd63, 1'b1, 64'h8000_0000_0000_0000);

    @(negedge clk);
    init  = 1'b1;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      din   = {$urandom, $urandom};
      shamt = 6'($urandom);
      rot   = 1'($urandom);
      @(negedge clk);
      if (done[1]) ndone++;
    end
    init = 1'b0;
    check("held init ops", 64'(ndone), 64'd4);
    repeat (8) @(negedge clk);

    @(negedge clk);
    init  = 1'b1;
    din   = 64'hFFFF_0000_FFFF_0000;
    shamt = 6'd8;
    rot   = 1'b1;
    @(negedge clk);
    init  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy[1]), 64'd0);
    check("abort done", 64'(done[1]), 64'd0);
    check("abort data", dout[1], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done[1]) ndone++;
    end
    check("no done after abort", 64'(ndone), 64'd0);
    run_op("post abort", 64'hFFFF_0000_FFFF_0000, 6'd8, 1'b1,
           64'hFF00_00FF_FF00_00FF);

    for (int s = 0; s < 64; s++) begin
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        init  = 1'b1;
        din   = {$urandom, $urandom};
        shamt = 6'(s);
        rot   = 1'(r);
        @(negedge clk);
        init = 1'b0;
        repeat (6) @(negedge clk);
      end
    end

    repeat (3000) begin
      @(negedge clk);
      init  = ($urandom_range(0, 3) != 0);
      din   = {$urandom, $urandom};
      shamt = 6'($urandom);
      rot   = 1'($urandom);
    end
    init = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
